// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage.
//
// Owns the program counter, presents it to a combinational instruction memory
// and captures the returned word into an IF/ID register. That register is
// handed to decode over a valid/ready handshake. Execute can redirect the PC,
// and fetch halts once the PC leaves the loaded program.
//
// Handshake: id_valid/id_ready follow strict valid/ready rules. A transfer
// happens on every rising edge where id_valid && id_ready. While
// id_valid && !id_ready, id_inst and id_pc hold their values. The only
// exception is a redirect, which flushes the slot.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   imem_addr       out  [31:0] fetch address (equals pc)
//   imem_inst       in   [31:0] word returned for imem_addr in the same cycle
//   id_valid        out  IF/ID slot holds an instruction
//   id_ready        in   decode accepts the held instruction this cycle
//   id_inst         out  [31:0] held instruction (NOP_INST when the slot is empty)
//   id_pc           out  [31:0] address of the held instruction
//   redirect_valid  in   execute requests a PC change
//   redirect_target in   [31:0] new PC; bits [1:0] are forced to zero
//   halted          out  fetch has stopped (registered)
//   fetch_count     out  [31:0] number of instructions loaded into IF/ID
//   fsm_state       out  debug view of the fetch FSM (0 = RUN, 1 = HALT)
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          INST_COUNT = 9,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic        fsm_state
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam logic [31:0] END_PC = RESET_PC + 32'(4 * INST_COUNT);

  state_e      state_q, state_d;
  logic        halted_q, halted_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        slot_free;
  logic        in_range;
  logic [31:0] redirect_pc;
  logic        redirect_in_range;
  logic        do_fetch;

  assign slot_free         = !id_valid_q || id_ready;
  assign in_range          = (pc_q >= RESET_PC) && (pc_q < END_PC);
  assign redirect_pc       = {redirect_target[31:2], 2'b00};
  assign redirect_in_range = (redirect_pc >= RESET_PC) && (redirect_pc < END_PC);
  // A redirect always takes priority, so it suppresses the fetch in its cycle.
  assign do_fetch          = !redirect_valid && (state_q == ST_RUN) && in_range && slot_free;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = redirect_in_range ? ST_RUN : ST_HALT;
    end else if ((state_q == ST_RUN) && !in_range) begin
      state_d = ST_HALT;
    end
  end

  // FSM: output logic. halted rises one cycle after HALT is entered. It drops
  // on the edge that leaves HALT, so it is already low when the first
  // redirected instruction is delivered.
  always_comb begin
    halted_d = (state_q == ST_HALT) && (state_d == ST_HALT);
  end

  // Datapath next-state: redirect > fetch > drain > stall (hold).
  always_comb begin
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end else if (do_fetch) begin
      pc_d          = pc_q + 32'd4;
      id_valid_d    = 1'b1;
      id_inst_d     = imem_inst;
      id_pc_d       = pc_q;
      fetch_count_d = fetch_count_q + 32'd1;
    end else if (slot_free) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_inst_q     <= NOP_INST;
      id_pc_q       <= 32'h0000_0000;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_inst     = id_inst_q;
  assign id_pc       = id_pc_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          INST_COUNT = 9;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] imem_addr, imem_inst, id_inst, id_pc, redirect_target, fetch_count;
  logic        id_valid, id_ready, redirect_valid, halted, fsm_state;

  inst_fetch #(
    .RESET_PC  (RESET_PC),
    .INST_COUNT(INST_COUNT),
    .NOP_INST  (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .fsm_state      (fsm_state)
  );

  // ---------------- instruction memory ----------------
  logic [31:0] mem [INST_COUNT];

  function automatic logic inr(input logic [31:0] a);
    return (a >= RESET_PC) && (a < RESET_PC + 32'(4 * INST_COUNT));
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - RESET_PC) >> 2;
    if (inr(a)) return mem[idx];
    return 32'h0000_0000;
  endfunction

  assign imem_inst = mem_word(imem_addr);

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: the program is a list of words. The model tracks where
  // fetch points, what the slot holds, whether fetching has stopped, and how
  // many words were loaded.
  logic [31:0] m_pc, m_inst, m_ipc, m_count;
  logic        m_valid, m_stopped, m_halted;

  task automatic model_reset();
    m_pc = RESET_PC; m_valid = 1'b0; m_inst = NOP; m_ipc = 32'h0;
    m_stopped = 1'b0; m_halted = 1'b0; m_count = 32'h0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic rdy, input logic rv, input logic [31:0] rt);
    logic nxt_stop;
    if (rv) begin
      m_pc = {rt[31:2], 2'b00};
      m_valid = 1'b0;
      m_inst = NOP;
      nxt_stop = !inr(m_pc);
    end else begin
      nxt_stop = m_stopped || !inr(m_pc);
      if (!m_valid || rdy) begin
        if (!m_stopped && inr(m_pc)) begin
          m_inst = mem_word(m_pc);
          m_ipc = m_pc;
          m_valid = 1'b1;
          m_pc = m_pc + 32'd4;
          m_count = m_count + 32'd1;
        end else begin
          m_valid = 1'b0;
          m_inst = NOP;
        end
      end
    end
    m_halted = m_stopped && nxt_stop;
    m_stopped = nxt_stop;
  endtask

  task automatic check_outputs();
    check("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
    check("imem_addr", imem_addr, m_pc);
    check("halted", {31'h0, halted}, {31'h0, m_halted});
    check("fetch_count", fetch_count, m_count);
    if (m_valid) begin
      check("id_pc", id_pc, m_ipc);
      check("id_inst", id_inst, m_inst);
    end else begin
      check("id_inst_nop", id_inst, NOP);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at (posedge + 1). Applies the inputs for one cycle and records
  // any accept that the model predicts.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rt);
    id_ready = rdy;
    redirect_valid = rv;
    redirect_target = rt;
    if (m_valid && rdy) exp_q.push_back({m_ipc, m_inst});
    @(posedge clk);
    #1;
    model_step(rdy, rv, rt);
    check_outputs();
  endtask

  task automatic do_reset();
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_id_valid", {31'h0, id_valid}, 32'h0);
    check("rst_id_inst", id_inst, NOP);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_fetch_count", fetch_count, 32'h0);
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_unexpected: got pc=%h inst=%h expected none", id_pc, id_inst);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("accept_pc", id_pc, e[63:32]);
        check("accept_inst", id_inst, e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] saved_count;

  initial begin
    mem[0] = 32'h00100293; mem[1] = 32'h00300313; mem[2] = 32'h0062B223;
    mem[3] = 32'h0002A383; mem[4] = 32'h00538433; mem[5] = 32'hFE000EE3;
    mem[6] = 32'h00A00513; mem[7] = 32'h006282B3; mem[8] = 32'h405383B3;
    id_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;

    // Straight-line run to the end of the program.
    do_reset();
    cycle(1'b1, 1'b0, 32'h0);
    check("c1_inst", id_inst, 32'h00100293);
    check("c1_pc", id_pc, 32'h0);
    check("c1_count", fetch_count, 32'd1);
    cycle(1'b1, 1'b0, 32'h0);
    check("c2_inst", id_inst, 32'h00300313);
    check("c2_pc", id_pc, 32'h4);
    check("c2_count", fetch_count, 32'd2);
    repeat (7) cycle(1'b1, 1'b0, 32'h0);
    check("last_pc", id_pc, 32'd32);
    check("last_inst", id_inst, 32'h405383B3);
    check("last_count", fetch_count, 32'd9);
    check("last_addr", imem_addr, 32'd36);
    cycle(1'b1, 1'b0, 32'h0);
    check("drain_valid", {31'h0, id_valid}, 32'h0);
    check("drain_inst", id_inst, NOP);
    check("drain_halted", {31'h0, halted}, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check("halt_asserted", {31'h0, halted}, 32'h1);
    check("halt_addr", imem_addr, 32'd36);
    check("halt_count", fetch_count, 32'd9);

    // Redirect out of HALT, then back to HALT, then to an out-of-range target.
    cycle(1'b1, 1'b1, 32'h4);
    check("redir_halted", {31'h0, halted}, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check("redir_pc", id_pc, 32'h4);
    check("redir_inst", id_inst, 32'h00300313);
    repeat (10) cycle(1'b1, 1'b0, 32'h0);
    check("rehalt", {31'h0, halted}, 32'h1);
    cycle(1'b1, 1'b1, 32'd100);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    check("oor_halted", {31'h0, halted}, 32'h1);
    check("oor_valid", {31'h0, id_valid}, 32'h0);
    check("oor_addr", imem_addr, 32'd100);

    // Backpressure and redirect during a stall.
    do_reset();
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      check("stall_pc", id_pc, 32'h8);
      check("stall_inst", id_inst, 32'h0062B223);
      check("stall_addr", imem_addr, 32'd12);
    end
    cycle(1'b1, 1'b0, 32'h0);
    check("unstall_pc", id_pc, 32'd12);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check("pre_flush_pc", id_pc, 32'd24);
    saved_count = fetch_count;
    cycle(1'b0, 1'b1, 32'h0000001F);
    check("flush_valid", {31'h0, id_valid}, 32'h0);
    check("flush_addr", imem_addr, 32'd28);
    check("flush_count", fetch_count, saved_count);
    cycle(1'b1, 1'b0, 32'h0);
    check("post_flush_pc", id_pc, 32'd28);
    check("post_flush_inst", id_inst, 32'h006282B3);
    check("post_flush_count", fetch_count, saved_count + 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic        rdy, rv;
      logic [31:0] rt;
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 14) == 0);
      rt  = ($urandom_range(0, 3) == 3) ? 32'($urandom_range(36, 200))
                                        : 32'($urandom_range(0, 35));
      cycle(rdy, rv, rt);
    end

    // Asynchronous reset in the middle of a run.
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    check("pre_async_valid", {31'h0, id_valid}, 32'h1);
    id_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("async_valid", {31'h0, id_valid}, 32'h0);
    check("async_addr", imem_addr, 32'h0);
    check("async_count", fetch_count, 32'h0);
    check("async_halted", {31'h0, halted}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) cycle(1'b1, 1'b0, 32'h0);

    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage that reads the combinational instruction memory.
- Owns the program counter and drives the memory address each cycle.
- Captures the returned word into an IF/ID output register and hands it to decode over a valid/ready handshake.
- Takes branch/jump redirects from execute, and halts once the PC leaves the loaded program.

Parameters:
- RESET_PC, 32'h0000_0000: PC value after reset.
- INST_COUNT, 9: number of valid words in instruction memory. The program end address is RESET_PC + 4*INST_COUNT.
- NOP_INST, 32'h0000_0013: value driven on id_inst while the output slot is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals pc combinationally.
- imem_inst  input  32  instruction word returned in the same cycle for imem_addr.
- id_valid  output  1  IF/ID register holds an instruction.
- id_ready  input  1  decode accepts the held instruction this cycle.
- id_inst  output  32  held instruction.
- id_pc  output  32  address of the held instruction.
- redirect_valid  input  1  execute requests a PC change (taken branch or jump).
- redirect_target  input  32  new PC; bits [1:0] are ignored and forced to 0.
- halted  output  1  fetch stopped because pc is at or beyond the program end.
- fetch_count  output  32  number of instructions loaded into the IF/ID register since reset; wraps modulo 2^32.

Behaviour:
- Reset (asynchronous, rst high):
  - pc = RESET_PC; id_valid = 0; id_inst = NOP_INST; id_pc = 0.
  - halted = 0; fetch_count = 0; state = RUN.
  - Any in-flight instruction is dropped.
- Definitions:
  - slot_free = !id_valid || id_ready.
  - in_range = (pc >= RESET_PC) && (pc < RESET_PC + 4*INST_COUNT).
- States:
  - RUN: fetch allowed.
  - HALT: no fetch. halted = 1 (registered, asserted the cycle after entry).
- Priority per cycle, highest first:
  1. Redirect: if redirect_valid, then pc <= {redirect_target[31:2],2'b00} and id_valid <= 0 (flush even if id_ready is low). id_inst returns to NOP_INST. No fetch this cycle and fetch_count is unchanged. The next state is RUN if the new pc is in range, otherwise HALT.
  2. Fetch: if state is RUN, in_range and slot_free, then:
     - id_inst <= imem_inst; id_pc <= pc; id_valid <= 1.
     - pc <= pc + 4 (32-bit wrap); fetch_count <= fetch_count + 1.
  3. Drain: if slot_free but no fetch (halting or out of range), then id_valid <= 0 and id_inst <= NOP_INST.
  4. Stall: if id_valid && !id_ready, all state is held. pc does not advance and imem_addr is stable.
- RUN -> HALT when no redirect is present and pc is not in range. The last in-range instruction is still delivered and drained normally.
- HALT -> RUN only through a redirect to an in-range target, or through reset.
- Latency:
  - An instruction at pc appears on id_inst one cycle after imem_addr = pc, provided the slot is free.
  - With id_ready held high, throughput is 1 instruction per cycle.
- Handshake rules:
  - id_inst and id_pc must not change while id_valid && !id_ready, unless a redirect arrives.
  - A redirect in the same cycle as a decode accept: the accept completes and the new slot is empty.
- Reset mid-stall or mid-redirect: reset wins immediately and asynchronously.

Test Plan:
- Reset then release, id_ready=1, imem returns words by index (mem[0]=32'h00100293):
  - cycle 1: id_inst=32'h00100293, id_pc=0.
  - cycle 2: id_inst=32'h00300313, id_pc=4.
  - fetch_count increments by 1 per cycle.
- Straight-line run to the end with INST_COUNT=9:
  - Last delivery is id_pc=32 with id_inst=32'h405383B3.
  - Next cycle: id_valid=0, id_inst=32'h00000013; halted=1 one cycle later.
  - imem_addr stays at 36; fetch_count=9.
- Backpressure: drop id_ready for 3 cycles while id_pc=8 (32'h0062B223) is held.
  - id_inst, id_pc and imem_addr=12 are stable for all 3 cycles.
  - Raising id_ready delivers id_pc=12 on the next cycle.
- Redirect during a stall (id_valid=1, id_ready=0, id_pc=24), with redirect_valid=1 and target=32'h0000001F:
  - Next cycle: id_valid=0 and pc=28.
  - Following cycle: id_pc=28, id_inst=32'h006282B3; fetch_count unchanged by the flush.
- Redirect from HALT (pc=36) to target 4 -> halted deasserts, then id_pc=4 and id_inst=32'h00300313 are delivered. Redirect to 100 -> stays in HALT with no valid output.
- Assert rst asynchronously mid-run (between clock edges, id_valid=1) -> id_valid=0, imem_addr=0, fetch_count=0 and halted=0 immediately, without waiting for a clock edge.
